sdram_cmd_sched: RTL and testbench

Command scheduler for the W9825G6KH SDRAM, active once power-up initialisation has finished. It arbitrates between one write requester, one read requester and an internal periodic auto-refresh timer. It issues ACTIVE, READ/WRITE with auto-precharge and AUTO REFRESH with fixed inter-command spacing. It also produces the write-data-enable and read-data-valid strobes that the datapath uses, and assumes the mode register holds burst length 8 and CAS latency 3.

---
 rtl/sdram_cmd_sched.sv | 175 +++++++++++++++++
 tb/tb_sdram_cmd_sched.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_cmd_sched.sv
// Command scheduler for the W9825G6KH SDRAM: arbitrates one writer, one reader and a
// periodic auto-refresh, issuing ACTIVE / READ|WRITE with auto-precharge / AUTO REFRESH.
module sdram_cmd_sched (
   input  logic        REF_CLK,
   input  logic        RST_N,
   input  logic        init_done,
   input  logic        wr_req,
   input  logic [23:0] wr_addr,
   output logic        wr_ack,
   output logic        wr_data_en,
   input  logic        rd_req,
   input  logic [23:0] rd_addr,
   output logic        rd_ack,
   output logic        rd_data_vld,
   output logic [3:0]  sdram_cmd,
   output logic [12:0] sdram_a,
   output logic [1:0]  sdram_ba,
   output logic        busy
);

   localparam int unsigned T_RCD      = 2;
   localparam int unsigned T_RC       = 8;
   localparam int unsigned WR_GAP     = 12;
   localparam int unsigned RD_GAP     = 13;
   localparam int unsigned CAS_LAT    = 3;
   localparam int unsigned BURST      = 8;
   localparam int unsigned REF_PERIOD = 780;
   localparam int unsigned REF_W      = $clog2(REF_PERIOD);
   localparam int unsigned CNT_W      = 4;
   localparam int unsigned BURST_W    = $clog2(BURST);

   localparam logic [3:0] CMD_NOP = 4'b0111;
   localparam logic [3:0] CMD_ACT = 4'b0011;
   localparam logic [3:0] CMD_RD  = 4'b0101;
   localparam logic [3:0] CMD_WR  = 4'b0100;
   localparam logic [3:0] CMD_REF = 4'b0001;

   typedef enum logic [1:0] {IDLE, ACT_WAIT, ACC_WAIT, REF_WAIT} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [REF_W-1:0]   ref_cnt;
   logic               ref_pending;
   logic               last_wr;
   logic               acc_wr;
   logic [1:0]         acc_ba;
   logic [8:0]         acc_col;
   logic [BURST_W-1:0] wr_left;
   logic [BURST_W-1:0] rd_left;
   logic [CAS_LAT-1:0] rd_dly;

   logic        pick_wr_c;
   logic [23:0] sel_addr_c;

   // Single requester wins outright; under contention alternate away from the last grant
   always_comb begin
      pick_wr_c  = wr_req && (!rd_req || !last_wr);
      sel_addr_c = pick_wr_c ? wr_addr : rd_addr;
   end

   always_ff @(posedge REF_CLK or negedge RST_N) begin
      if (!RST_N) begin
         state       <= IDLE;
         cnt         <= '0;
         ref_cnt     <= '0;
         ref_pending <= 1'b0;
         last_wr     <= 1'b0;
         acc_wr      <= 1'b0;
         acc_ba      <= '0;
         acc_col     <= '0;
         wr_left     <= '0;
         rd_left     <= '0;
         rd_dly      <= '0;
         sdram_cmd   <= CMD_NOP;
         sdram_a     <= '0;
         sdram_ba    <= '0;
         wr_ack      <= 1'b0;
         rd_ack      <= 1'b0;
         wr_data_en  <= 1'b0;
         rd_data_vld <= 1'b0;
         busy        <= 1'b0;
      end else begin
         sdram_cmd <= CMD_NOP;
         sdram_a   <= '0;
         sdram_ba  <= '0;
         wr_ack    <= 1'b0;
         rd_ack    <= 1'b0;
         rd_dly    <= {rd_dly[CAS_LAT-2:0], 1'b0};

         // Burst strobes run off their own counters once launched
         if (wr_left != '0) wr_left <= wr_left - BURST_W'(1);
         else               wr_data_en <= 1'b0;

         if (rd_dly[CAS_LAT-1]) begin
            rd_data_vld <= 1'b1;
            rd_left     <= BURST_W'(BURST - 1);
         end else if (rd_left != '0) begin
            rd_left <= rd_left - BURST_W'(1);
         end else begin
            rd_data_vld <= 1'b0;
         end

         if (!init_done) begin
            state       <= IDLE;
            busy        <= 1'b0;
            ref_cnt     <= '0;
            ref_pending <= 1'b0;
         end else begin
            if (ref_cnt == REF_W'(REF_PERIOD - 1)) begin
               ref_cnt     <= '0;
               ref_pending <= 1'b1;
            end else begin
               ref_cnt <= ref_cnt + REF_W'(1);
            end

            case (state)
               IDLE: begin
                  if (ref_pending) begin
                     sdram_cmd   <= CMD_REF;
                     ref_pending <= 1'b0;
                     cnt         <= CNT_W'(T_RC - 2);
                     state       <= REF_WAIT;
                     busy        <= 1'b1;
                  end else if (wr_req || rd_req) begin
                     sdram_cmd <= CMD_ACT;
                     sdram_ba  <= sel_addr_c[23:22];
                     sdram_a   <= sel_addr_c[21:9];
                     acc_wr    <= pick_wr_c;
                     acc_ba    <= sel_addr_c[23:22];
                     acc_col   <= sel_addr_c[8:0];
                     last_wr   <= pick_wr_c;
                     cnt       <= CNT_W'(T_RCD - 1);
                     state     <= ACT_WAIT;
                     busy      <= 1'b1;
                  end
               end
               ACT_WAIT: begin
                  if (cnt == '0) begin
                     sdram_ba <= acc_ba;
                     sdram_a  <= {2'b00, 1'b1, 1'b0, acc_col};
                     state    <= ACC_WAIT;
                     if (acc_wr) begin
                        sdram_cmd  <= CMD_WR;
                        wr_ack     <= 1'b1;
                        wr_data_en <= 1'b1;
                        wr_left    <= BURST_W'(BURST - 1);
                        cnt        <= CNT_W'(WR_GAP - 2);
                     end else begin
                        sdram_cmd <= CMD_RD;
                        rd_ack    <= 1'b1;
                        rd_dly    <= {rd_dly[CAS_LAT-2:0], 1'b1};
                        cnt       <= CNT_W'(RD_GAP - 2);
                     end
                  end else begin
                     cnt <= cnt - CNT_W'(1);
                  end
               end
               ACC_WAIT, REF_WAIT: begin
                  if (cnt == '0) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     cnt <= cnt - CNT_W'(1);
                  end
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sdram_cmd_sched.sv
// Scoreboard bench for sdram_cmd_sched: stimulus queues expected bus commands with
// absolute cycle offsets; a monitor pops and checks them plus acks and data strobes.
module tb_sdram_cmd_sched;

   localparam logic [3:0] NOP = 4'b0111;
   localparam logic [3:0] ACT = 4'b0011;
   localparam logic [3:0] RD  = 4'b0101;
   localparam logic [3:0] WR  = 4'b0100;
   localparam logic [3:0] REF = 4'b0001;

   logic        ref_clk;
   logic        rst_n;
   logic        init_done;
   logic        wr_req;
   logic [23:0] wr_addr;
   logic        wr_ack;
   logic        wr_data_en;
   logic        rd_req;
   logic [23:0] rd_addr;
   logic        rd_ack;
   logic        rd_data_vld;
   logic [3:0]  sdram_cmd;
   logic [12:0] sdram_a;
   logic [1:0]  sdram_ba;
   logic        busy;

   typedef struct {
      logic [3:0]  cmd;
      logic [12:0] a;
      logic [1:0]  ba;
      int          t;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   int   t0    = 0;

   sdram_cmd_sched dut (
      .REF_CLK    (ref_clk),
      .RST_N      (rst_n),
      .init_done  (init_done),
      .wr_req     (wr_req),
      .wr_addr    (wr_addr),
      .wr_ack     (wr_ack),
      .wr_data_en (wr_data_en),
      .rd_req     (rd_req),
      .rd_addr    (rd_addr),
      .rd_ack     (rd_ack),
      .rd_data_vld(rd_data_vld),
      .sdram_cmd  (sdram_cmd),
      .sdram_a    (sdram_a),
      .sdram_ba   (sdram_ba),
      .busy       (busy)
   );

   initial begin
      ref_clk = 1'b0;
      forever #5 ref_clk = ~ref_clk;
   end

   always @(posedge ref_clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at offset %0d: got %0h expected %0h", name, cyc - t0, act, exp);
      end
   endtask

   task automatic push(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] a, input int t);
      exp_t e;
      e.cmd = c; e.ba = ba; e.a = a; e.t = t;
      q.push_back(e);
   endtask

   task automatic wait_ack(input bit wr, input string name);
      int k;
      k = 0;
      @(negedge ref_clk);
      while (!(wr ? wr_ack : rd_ack) && k < 60) begin
         @(negedge ref_clk);
         k++;
      end
      check(name, 32'(wr ? wr_ack : rd_ack), 32'(1));
      check({name, "_busy"}, 32'(busy), 32'(1));
   endtask

   task automatic wait_until(input int off);
      while (cyc - t0 < off) @(negedge ref_clk);
   endtask

   task automatic check_reset_outs(input string tag);
      check({tag, "_cmd"},   32'(sdram_cmd),   32'(NOP));
      check({tag, "_a"},     32'(sdram_a),     32'(0));
      check({tag, "_ba"},    32'(sdram_ba),    32'(0));
      check({tag, "_wrack"}, 32'(wr_ack),      32'(0));
      check({tag, "_rdack"}, 32'(rd_ack),      32'(0));
      check({tag, "_wren"},  32'(wr_data_en),  32'(0));
      check({tag, "_rdvld"}, 32'(rd_data_vld), 32'(0));
      check({tag, "_busy"},  32'(busy),        32'(0));
   endtask

   // Monitor: pops the scoreboard on every non-NOP command, models ack/strobe timing
   initial begin
      exp_t e;
      int   lw, lr;
      bit   vw, vr, exp_wa, exp_ra;
      lw = 0; lr = 0; vw = 1'b0; vr = 1'b0;
      forever begin
         @(negedge ref_clk);
         if (!rst_n) begin
            vw = 1'b0;
            vr = 1'b0;
            continue;
         end
         exp_wa = 1'b0;
         exp_ra = 1'b0;
         if (sdram_cmd != NOP) begin
            if (q.size() == 0) begin
               check("unexpected_cmd", 32'(sdram_cmd), 32'(NOP));
            end else begin
               e = q.pop_front();
               check("cmd",      32'(sdram_cmd), 32'(e.cmd));
               check("cmd_a",    32'(sdram_a),   32'(e.a));
               check("cmd_ba",   32'(sdram_ba),  32'(e.ba));
               check("cmd_time", 32'(cyc - t0),  32'(e.t));
               exp_wa = (e.cmd == WR);
               exp_ra = (e.cmd == RD);
               if (exp_wa) begin lw = cyc; vw = 1'b1; end
               if (exp_ra) begin lr = cyc; vr = 1'b1; end
            end
         end else begin
            check("nop_a",  32'(sdram_a),  32'(0));
            check("nop_ba", 32'(sdram_ba), 32'(0));
         end
         check("wr_ack",      32'(wr_ack),      32'(exp_wa));
         check("rd_ack",      32'(rd_ack),      32'(exp_ra));
         check("wr_data_en",  32'(wr_data_en),  32'(vw && (cyc - lw) < 8));
         check("rd_data_vld", 32'(rd_data_vld), 32'(vr && (cyc - lr) >= 3 && (cyc - lr) <= 10));
      end
   end

   initial begin
      rst_n = 1'b0; init_done = 1'b0;
      wr_req = 1'b0; rd_req = 1'b0; wr_addr = '0; rd_addr = '0;
      repeat (3) @(negedge ref_clk);
      check_reset_outs("reset");
      #2 rst_n = 1'b1;

      // Held off by init_done: any command here is flagged by the monitor
      wr_req = 1'b1; wr_addr = 24'hC0_2A05;
      repeat (1000) @(negedge ref_clk);
      check("init_busy", 32'(busy), 32'(0));

      push(ACT, 2'd3, 13'h0015, 0);
      push(WR,  2'd3, 13'h0405, 2);
      t0 = cyc + 1;
      init_done = 1'b1;
      wait_ack(1'b1, "wr1_ack");
      wr_req = 1'b0;

      push(ACT, 2'd0, 13'h0001, 14);
      push(RD,  2'd0, 13'h0400, 16);
      rd_addr = 24'h00_0200; rd_req = 1'b1;
      wait_ack(1'b0, "rd1_ack");

      // Contended: both held, grants alternate starting with write
      wr_addr = 24'h4A_4C12; rd_addr = 24'h85_F1FF;
      push(ACT, 2'd1, 13'h0526, 29); push(WR, 2'd1, 13'h0412, 31);
      push(ACT, 2'd2, 13'h02F8, 43); push(RD, 2'd2, 13'h05FF, 45);
      push(ACT, 2'd1, 13'h0526, 58); push(WR, 2'd1, 13'h0412, 60);
      push(ACT, 2'd2, 13'h02F8, 72); push(RD, 2'd2, 13'h05FF, 74);
      wr_req = 1'b1; rd_req = 1'b1;
      for (int g = 0; g < 4; g++) wait_ack(g % 2 == 0, "cont_ack");
      wr_req = 1'b0; rd_req = 1'b0;

      // Idle refreshes, then one landing during a read and beating a waiting write
      push(REF, 2'd0, 13'h0000, 780);
      push(REF, 2'd0, 13'h0000, 1560);
      wait_until(2329);
      check("idle_busy", 32'(busy), 32'(0));
      push(ACT, 2'd0, 13'h0001, 2330); push(RD, 2'd0, 13'h0400, 2332);
      push(REF, 2'd0, 13'h0000, 2345);
      push(ACT, 2'd3, 13'h0015, 2353); push(WR, 2'd3, 13'h0405, 2355);
      rd_addr = 24'h00_0200; rd_req = 1'b1;
      wait_ack(1'b0, "rd2_ack");
      rd_req = 1'b0;
      wait_until(2335);
      wr_addr = 24'hC0_2A05; wr_req = 1'b1;
      wait_ack(1'b1, "wr2_ack");
      wr_req = 1'b0;

      // Reset in the middle of a read burst
      wait_until(2399);
      push(ACT, 2'd0, 13'h0001, 2400); push(RD, 2'd0, 13'h0400, 2402);
      rd_req = 1'b1;
      wait_ack(1'b0, "rd3_ack");
      rd_req = 1'b0;
      wait_until(2407);
      check("pre_rst_vld", 32'(rd_data_vld), 32'(1));
      #2 rst_n = 1'b0;
      #1 check_reset_outs("midrst");
      repeat (3) @(negedge ref_clk);
      #2 rst_n = 1'b1;
      @(negedge ref_clk);
      check_reset_outs("postrst");

      push(ACT, 2'd3, 13'h0015, 0);
      push(WR,  2'd3, 13'h0405, 2);
      t0 = cyc + 1;
      wr_req = 1'b1;
      wait_ack(1'b1, "wr3_ack");
      wr_req = 1'b0;
      repeat (20) @(negedge ref_clk);
      check("final_busy",  32'(busy),     32'(0));
      check("queue_empty", 32'(q.size()), 32'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
